// File: rtl/add32_seq_arbiter.sv
// add32_seq_arbiter: round-robin shared 16-bit ripple slice doing 32-bit add/sub in two passes.
// Optional subtraction is enabled by defining ADD32_SEQ_SUB_EN.
module add32_seq_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqA,
  input  logic        reqB,
  input  logic [31:0] in1A,
  input  logic [31:0] in2A,
  input  logic [31:0] in1B,
  input  logic [31:0] in2B,
  input  logic        subA,
  input  logic        subB,
  output logic        ackA,
  output logic        ackB,
  output logic        busy,
  output logic        resValid,
  output logic        resId,
  output logic [31:0] resSum,
  output logic        resCout,
  output logic        resOvf
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_DONE = 2'd3;
  logic [1:0]  r_state;
  logic        r_last, r_gnt_id, r_carry_mid, r_id, r_cout, r_ovf;
  logic [31:0] r_op1, r_op2, r_sum;
  logic [15:0] r_sum_lo;
  logic        w_req, w_gnt_b, w_sub, w_hi;
  logic [31:0] w_op2x;
  logic [15:0] w_a, w_b, w_s;
  logic [16:0] w_c;
  assign w_req   = reqA | reqB;
  assign w_gnt_b = reqB & (~reqA | ~r_last);
`ifdef ADD32_SEQ_SUB_EN
  logic r_sub;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sub <= 1'b0;
    else if (r_state == S_IDLE && w_req) r_sub <= w_gnt_b ? subB : subA;
  assign w_sub = r_sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = subA ^ subB;
  assign w_sub = 1'b0;
`endif
  assign w_op2x = w_sub ? ~r_op2 : r_op2;
  assign w_hi   = r_state == S_HI;
  assign w_a    = w_hi ? r_op1[31:16] : r_op1[15:0];
  assign w_b    = w_hi ? w_op2x[31:16] : w_op2x[15:0];
  // the LO pass takes the +1 of two's-complement negation as its carry in
  assign w_c[0] = w_hi ? r_carry_mid : w_sub;
  for (genvar i = 0; i < 16; i++) begin : g_rip
    assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_gnt_id    <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_sum_lo    <= '0;
      r_carry_mid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_id        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_state  <= S_LO;
          r_op1    <= w_gnt_b ? in1B : in1A;
          r_op2    <= w_gnt_b ? in2B : in2A;
          r_gnt_id <= w_gnt_b;
          r_last   <= w_gnt_b;
        end
        S_LO: begin
          r_sum_lo    <= w_s;
          r_carry_mid <= w_c[16];
          r_state     <= S_HI;
        end
        S_HI: begin
          r_sum   <= {w_s, r_sum_lo};
          r_cout  <= w_c[16];
          r_ovf   <= (r_op1[31] == w_op2x[31]) && (w_s[15] != r_op1[31]);
          r_id    <= r_gnt_id;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign ackA     = r_state == S_LO && !r_gnt_id;
  assign ackB     = r_state == S_LO && r_gnt_id;
  assign busy     = r_state != S_IDLE;
  assign resValid = r_state == S_DONE;
  assign resId    = r_id;
  assign resSum   = r_sum;
  assign resCout  = r_cout;
  assign resOvf   = r_ovf;
endmodule

// File: tb/tb_add32_seq_arbiter.sv
// tb_add32_seq_arbiter: scoreboard bench for add32_seq_arbiter (expectations follow ADD32_SEQ_SUB_EN).
module tb_add32_seq_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, reqA = 1'b0, reqB = 1'b0, subA = 1'b0, subB = 1'b0;
  logic [31:0] in1A = '0, in2A = '0, in1B = '0, in2B = '0;
  logic ackA, ackB, busy, resValid, resId, resCout, resOvf;
  logic [31:0] resSum;
  typedef struct packed { logic id; logic [31:0] sum; logic cout; logic ovf; } res_t;
  res_t sb[$];
  int checks = 0, errors = 0;

  add32_seq_arbiter dut (
    .clk(clk), .rst_n(rst_n), .reqA(reqA), .reqB(reqB),
    .in1A(in1A), .in2A(in2A), .in1B(in1B), .in2B(in2B),
    .subA(subA), .subB(subB), .ackA(ackA), .ackB(ackB), .busy(busy),
    .resValid(resValid), .resId(resId), .resSum(resSum),
    .resCout(resCout), .resOvf(resOvf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic res_t model(input logic id, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic se;
    logic [31:0] bx;
    logic [32:0] t;
`ifdef ADD32_SEQ_SUB_EN
    se = s;
`else
    se = 1'b0;
`endif
    bx = se ? ~b : b;
    t = {1'b0, a} + {1'b0, bx} + {32'd0, se};
    return '{id, t[31:0], t[32], (a[31] == bx[31]) && (t[31] != a[31])};
  endfunction

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (id) begin reqB = 1'b1; in1B = a; in2B = b; subB = s; end
    else begin reqA = 1'b1; in1A = a; in2A = b; subA = s; end
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int ack_n, output int res_n);
    ack_n = -1;
    res_n = -1;
    @(posedge clk); #1;
    drive(id, a, b, s);
    for (int n = 1; n <= 12 && res_n < 0; n++) begin
      @(negedge clk);
      if (ack_n < 0 && (id ? ackB : ackA)) begin
        ack_n = n;
        if (id) reqB = 1'b0; else reqA = 1'b0;
      end
      if (resValid) res_n = n;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ackA, ackB, resValid, resId, resCout, resOvf} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000", {busy, ackA, ackB, resValid, resId, resCout, resOvf});
    end
    checks++;
    if (resSum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 00000000", resSum); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops;
    logic id_t[8];
    logic [31:0] a_t[8], b_t[8];
    logic s_t[8];
    res_t e;
    int ack_n, res_n;
    id_t[0] = 0; a_t[0] = 32'h0000FFFF; b_t[0] = 32'h1; s_t[0] = 0;
    id_t[1] = 1; a_t[1] = 32'hFFFFFFFF; b_t[1] = 32'h1; s_t[1] = 0;
    id_t[2] = 0; a_t[2] = 32'h7FFFFFFF; b_t[2] = 32'h1; s_t[2] = 0;
    id_t[3] = 0; a_t[3] = 32'h5;        b_t[3] = 32'h7; s_t[3] = 1;
    for (int k = 4; k < 8; k++) begin
      id_t[k] = k[0]; a_t[k] = $urandom; b_t[k] = $urandom; s_t[k] = $urandom_range(0, 1) == 1;
    end
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: sb.push_back('{1'b0, 32'h00010000, 1'b0, 1'b0});
        1: sb.push_back('{1'b1, 32'h00000000, 1'b1, 1'b0});
        2: sb.push_back('{1'b0, 32'h80000000, 1'b0, 1'b1});
`ifdef ADD32_SEQ_SUB_EN
        3: sb.push_back('{1'b0, 32'hFFFFFFFE, 1'b0, 1'b0});
`else
        3: sb.push_back('{1'b0, 32'h0000000C, 1'b0, 1'b0});
`endif
        default: sb.push_back(model(id_t[k], a_t[k], b_t[k], s_t[k]));
      endcase
      issue(id_t[k], a_t[k], b_t[k], s_t[k], ack_n, res_n);
      checks++;
      if (ack_n !== 2) begin errors++; $display("FAIL op%0d_ack_lat: got %0d want 2", k, ack_n); end
      checks++;
      if (res_n !== 4) begin errors++; $display("FAIL op%0d_res_lat: got %0d want 4", k, res_n); end
      e = sb.pop_front();
      checks++;
      if ({resId, resSum, resCout, resOvf} !== e) begin
        errors++;
        $display("FAIL op%0d_result: got id=%b sum=%h c=%b v=%b want id=%b sum=%h c=%b v=%b",
                 k, resId, resSum, resCout, resOvf, e.id, e.sum, e.cout, e.ovf);
      end
      @(negedge clk);
      checks++;
      if ({resValid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL op%0d_pulse_end: got valid,busy=%b want 00", k, {resValid, busy});
      end
    end
  endtask

  task automatic test_tie;
    int a_n = -1, b_n = -1, v_cnt = 0, v_n[2];
    logic v_id[2];
    logic dbl = 1'b0;
    res_t e;
    test_reset;
    @(posedge clk); #1;
    sb.push_back(model(1'b0, 32'h00001234, 32'h00000100, 1'b0));
    sb.push_back(model(1'b1, 32'h80000000, 32'h80000000, 1'b0));
    drive(1'b0, 32'h00001234, 32'h00000100, 1'b0);
    drive(1'b1, 32'h80000000, 32'h80000000, 1'b0);
    for (int n = 1; n <= 20 && v_cnt < 2; n++) begin
      @(negedge clk);
      if (ackA && ackB) dbl = 1'b1;
      if (ackA && a_n < 0) begin a_n = n; reqA = 1'b0; end
      if (ackB && b_n < 0) begin b_n = n; reqB = 1'b0; end
      if (resValid) begin
        v_n[v_cnt] = n;
        v_id[v_cnt] = resId;
        e = sb.pop_front();
        checks++;
        if ({resId, resSum, resCout, resOvf} !== e) begin
          errors++;
          $display("FAIL tie_result%0d: got id=%b sum=%h c=%b v=%b want id=%b sum=%h c=%b v=%b",
                   v_cnt, resId, resSum, resCout, resOvf, e.id, e.sum, e.cout, e.ovf);
        end
        v_cnt++;
      end
    end
    checks++;
    if (v_cnt !== 2) begin errors++; $display("FAIL tie_valid_count: got %0d want 2", v_cnt); end
    checks++;
    if (dbl !== 1'b0) begin errors++; $display("FAIL tie_double_ack: both acks high together"); end
    checks++;
    if (a_n !== 2 || b_n !== 6) begin errors++; $display("FAIL tie_ack_times: got A=%0d B=%0d want A=2 B=6", a_n, b_n); end
    if (v_cnt == 2) begin
      checks++;
      if (v_n[1] - v_n[0] !== 4 || v_id[0] !== 1'b0 || v_id[1] !== 1'b1) begin
        errors++;
        $display("FAIL tie_order: got gap=%0d ids=%b%b want gap=4 ids=01", v_n[1] - v_n[0], v_id[0], v_id[1]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] seq = '0;
    int acks = 0, v_cnt = 0;
    res_t e;
    test_reset;
    @(posedge clk); #1;
    sb.push_back(model(1'b0, 32'h0000000A, 32'h00000003, 1'b0));
    sb.push_back(model(1'b1, 32'h00FF00FF, 32'h00010001, 1'b0));
    sb.push_back(model(1'b0, 32'h0000000A, 32'h00000003, 1'b0));
    drive(1'b0, 32'h0000000A, 32'h00000003, 1'b0);
    drive(1'b1, 32'h00FF00FF, 32'h00010001, 1'b0);
    for (int n = 1; n <= 24 && v_cnt < 3; n++) begin
      @(negedge clk);
      if ((ackA || ackB) && acks < 3) begin
        seq[acks] = ackB;
        acks++;
        if (acks == 3) begin reqA = 1'b0; reqB = 1'b0; end
      end
      if (resValid) begin
        e = sb.pop_front();
        checks++;
        if ({resId, resSum, resCout, resOvf} !== e) begin
          errors++;
          $display("FAIL rr_result%0d: got id=%b sum=%h want id=%b sum=%h", v_cnt, resId, resSum, e.id, e.sum);
        end
        v_cnt++;
      end
    end
    reqA = 1'b0;
    reqB = 1'b0;
    checks++;
    if (acks !== 3 || seq !== 3'b010) begin
      errors++;
      $display("FAIL rr_sequence: got acks=%0d seq(B bits, first at lsb)=%b want 3 010", acks, seq);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_op;
    res_t e;
    @(posedge clk); #1;
    drive(1'b0, 32'h12345678, 32'h11111111, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (ackA !== 1'b1) begin errors++; $display("FAIL mid_pre_ack: got %b want 1", ackA); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || resSum === 32'h0) begin
      errors++;
      $display("FAIL mid_pre_state: got busy=%b sum=%h want busy=1 sum nonzero", busy, resSum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ackA, ackB, resValid, resId, resCout, resOvf, resSum} !== 39'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%b acks=%b%b valid=%b id=%b c=%b v=%b sum=%h want all 0",
               busy, ackA, ackB, resValid, resId, resCout, resOvf, resSum);
    end
    @(negedge clk);
    checks++;
    if ({resValid, busy, ackA} !== 3'b0) begin
      errors++;
      $display("FAIL mid_reset_held: got valid,busy,ackA=%b want 000", {resValid, busy, ackA});
    end
    rst_n = 1'b1;
    sb.push_back(model(1'b0, 32'h12345678, 32'h11111111, 1'b0));
    @(negedge clk);
    checks++;
    if (ackA !== 1'b1 || resValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reack: got ackA=%b valid=%b want 1 0", ackA, resValid);
    end
    reqA = 1'b0;
    @(negedge clk);
    checks++;
    if (resValid !== 1'b0) begin errors++; $display("FAIL mid_no_early_valid: got %b want 0", resValid); end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (resValid !== 1'b1 || {resId, resSum, resCout, resOvf} !== e) begin
      errors++;
      $display("FAIL mid_result: got valid=%b id=%b sum=%h want valid=1 id=%b sum=%h", resValid, resId, resSum, e.id, e.sum);
    end
  endtask

  initial begin
    test_reset;
    test_single_ops;
    test_tie;
    test_round_robin;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
